// File: rtl/prince_affine_pipe.sv
// prince_affine_pipe
//   Share-wise PRINCE affine nibble map (forward or inverse, chosen per
//   transaction) followed by an elastic valid/ready register pipeline.
//   Each share is transformed by its own logic cone, so shares never mix
//   before the first register, and stages isolate neighbouring S-box layers.
//
//   Optional feature: define PRINCE_AFFINE_CONST_EN to XOR the CONST
//   parameter into share 0 (after the forward map, before the inverse map).
//   Without the macro the map is purely linear on every share.
//
// Ports
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready: upstream handshake; i_inv selects inverse map
//   i_data         : SHARES*NIBBLES nibbles, share s at [s*NIBBLES*4 +: NIBBLES*4]
//   o_valid/i_ready: downstream handshake
//   o_data, o_inv  : transformed shares and the carried i_inv flag
//   o_count        : number of occupied stages
module prince_affine_pipe #(
  parameter int         SHARES  = 3,
  parameter int         NIBBLES = 16,
  parameter int         STAGES  = 1,
  parameter logic [3:0] CONST   = 4'hA
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_valid,
  output logic                              o_ready,
  input  logic                              i_inv,
  input  logic [SHARES*NIBBLES*4-1:0]       i_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [SHARES*NIBBLES*4-1:0]       o_data,
  output logic                              o_inv,
  output logic [$clog2(STAGES+1)-1:0]       o_count
);

  localparam int W  = SHARES * NIBBLES * 4;
  localparam int CW = $clog2(STAGES + 1);

`ifdef PRINCE_AFFINE_CONST_EN
  localparam logic [3:0] CONST_MASK = 4'hF;
`else
  localparam logic [3:0] CONST_MASK = 4'h0;
`endif
  // Constant actually applied to share 0 (zero when the feature is off).
  localparam logic [3:0] SHARE0_CONST = CONST & CONST_MASK;

  // Nibble bit b0 is the MSB: b0=n[3], b1=n[2], b2=n[1], b3=n[0].
  function automatic logic [3:0] fwd_nib(input logic [3:0] n);
    return {n[2], n[3], n[0] ^ n[1] ^ n[2], n[1]};
  endfunction

  function automatic logic [3:0] inv_nib(input logic [3:0] n);
    return {n[2], n[3], n[0], n[3] ^ n[1] ^ n[0]};
  endfunction

  // ---------------------------------------------------------------
  // Input transform: one independent cone per nibble of each share
  // ---------------------------------------------------------------
  logic [W-1:0] xform;

  for (genvar gi = 0; gi < SHARES; gi++) begin : g_share
    localparam logic [3:0] K = (gi == 0) ? SHARE0_CONST : 4'h0;
    for (genvar gj = 0; gj < NIBBLES; gj++) begin : g_nib
      logic [3:0] nib_in;
      assign nib_in = i_data[(gi*NIBBLES+gj)*4 +: 4];
      // Constant goes in before the inverse so inverse undoes forward exactly.
      assign xform[(gi*NIBBLES+gj)*4 +: 4] =
        i_inv ? inv_nib(nib_in ^ K) : (fwd_nib(nib_in) ^ K);
    end
  end

  // ---------------------------------------------------------------
  // Elastic stage chain
  // ---------------------------------------------------------------
  logic [STAGES-1:0] valid_vec;
  logic [STAGES-1:0] inv_vec;
  logic [W-1:0]      data_arr [STAGES];
  logic [STAGES-1:0] load;

  // Load enables ripple from the output back to the input: a stage may load
  // when empty or when its successor (or the downstream) takes its content.
  always_comb begin : p_load
    logic take;
    take = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !valid_vec[k] || take;
      take    = load[k];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic         valid_d, valid_q;
    logic         inv_d, inv_q;
    logic [W-1:0] data_d, data_q;
    logic         src_valid, src_inv;
    logic [W-1:0] src_data;

    if (gi == 0) begin : g_head
      assign src_valid = i_valid;
      assign src_inv   = i_inv;
      assign src_data  = xform;
    end else begin : g_tail
      assign src_valid = valid_vec[gi-1];
      assign src_inv   = inv_vec[gi-1];
      assign src_data  = data_arr[gi-1];
    end

    always_comb begin
      valid_d = valid_q;
      inv_d   = inv_q;
      data_d  = data_q;
      if (load[gi]) begin
        valid_d = src_valid;
        // Payload only moves with a valid token; otherwise it holds.
        if (src_valid) begin
          inv_d  = src_inv;
          data_d = src_data;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        inv_q   <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        inv_q   <= inv_d;
        data_q  <= data_d;
      end
    end

    assign valid_vec[gi] = valid_q;
    assign inv_vec[gi]   = inv_q;
    assign data_arr[gi]  = data_q;
  end

  // ---------------------------------------------------------------
  // Occupancy counter
  // ---------------------------------------------------------------
  logic          accept, emit;
  logic [CW-1:0] count_d, count_q;

  assign accept = i_valid && load[0];
  assign emit   = valid_vec[STAGES-1] && i_ready;

  always_comb begin
    count_d = count_q;
    if (accept && !emit) begin
      count_d = count_q + CW'(1);
    end else if (emit && !accept) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_ready = load[0];
  assign o_valid = valid_vec[STAGES-1];
  assign o_inv   = inv_vec[STAGES-1];
  assign o_data  = data_arr[STAGES-1];
  assign o_count = count_q;

endmodule
